// File: rtl/y86_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : y86_pkg                                                  |
// | Purpose   : Shared Y86-64 constants: instruction codes, the "no      |
// |             register" id and the stack pointer id.                   |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] RSP      = 4'h4;

  localparam int unsigned NUM_REGS = 15;

endpackage : y86_pkg
`default_nettype wire

// File: rtl/decode_regfile_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : decode_regfile_if                                        |
// | Purpose   : Decode request, writeback and registered operand bundle  |
// |             of the decode stage register file.                       |
// | Ports     : dec_valid/icode/rA/rB        decode request              |
// |             wb_valid/wb_dst*/wb_val*     writeback                   |
// |             valA/valB/srcA_q/srcB_q/     registered decode result    |
// |             out_valid                                                |
// | Modports  : master (pipeline side), slave (decode_regfile)           |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface decode_regfile_if #(
  parameter int W = 64
);

  logic         dec_valid;
  logic [3:0]   icode;
  logic [3:0]   rA;
  logic [3:0]   rB;
  logic         wb_valid;
  logic [3:0]   wb_dstE;
  logic [3:0]   wb_dstM;
  logic [W-1:0] wb_valE;
  logic [W-1:0] wb_valM;
  logic [W-1:0] valA;
  logic [W-1:0] valB;
  logic [3:0]   srcA_q;
  logic [3:0]   srcB_q;
  logic         out_valid;

  modport master (
    output dec_valid, icode, rA, rB,
    output wb_valid, wb_dstE, wb_dstM, wb_valE, wb_valM,
    input  valA, valB, srcA_q, srcB_q, out_valid
  );

  modport slave (
    input  dec_valid, icode, rA, rB,
    input  wb_valid, wb_dstE, wb_dstM, wb_valE, wb_valM,
    output valA, valB, srcA_q, srcB_q, out_valid
  );

endinterface : decode_regfile_if
`default_nettype wire

// File: rtl/y86_src_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : y86_src_sel                                              |
// | Purpose   : Combinational source register selection for Y86-64.      |
// | Ports     : icode, rA, rB (in)  -> srcA, srcB (out)                  |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module y86_src_sel
  import y86_pkg::*;
(
  input  wire logic [3:0] icode,
  input  wire logic [3:0] rA,
  input  wire logic [3:0] rB,
  output logic      [3:0] srcA,
  output logic      [3:0] srcB
);

  always_comb begin
    srcA = RNONE;
    unique case (icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = rA;
      I_RET, I_POPQ:                      srcA = RSP;
      default:                            srcA = RNONE;
    endcase
  end

  always_comb begin
    srcB = RNONE;
    unique case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcB = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcB = RSP;
      default:                            srcB = RNONE;
    endcase
  end

endmodule : y86_src_sel
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : decode_regfile                                           |
// | Purpose   : Y86-64 decode stage: 15-entry register file with         |
// |             writeback-to-read bypass and registered operands.        |
// | Ports     : clk, rst (async, active-high)                            |
// |             bus : decode_regfile_if.slave (request/writeback/result) |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module decode_regfile
  import y86_pkg::*;
#(
  parameter int           W        = 64,
  parameter logic [W-1:0] RSP_INIT = 64'h0000_0000_0000_0200
) (
  input wire logic         clk,
  input wire logic         rst,
  decode_regfile_if.slave  bus
);

  logic [3:0]         w_srcA;
  logic [3:0]         w_srcB;
  logic [15:0][W-1:0] w_rf;     // id 15 is a hard-wired zero entry
  logic [W-1:0]       w_opA;
  logic [W-1:0]       w_opB;

  logic [W-1:0]       r_valA;
  logic [W-1:0]       r_valB;
  logic [3:0]         r_srcA_q;
  logic [3:0]         r_srcB_q;
  logic               r_out_valid;

  y86_src_sel u_src_sel (
    .icode (bus.icode),
    .rA    (bus.rA),
    .rB    (bus.rB),
    .srcA  (w_srcA),
    .srcB  (w_srcB)
  );

  // One register per id; M is tested first so it wins when both ports
  // target the same register.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [3:0]   c_id  = 4'(gi);
    localparam logic [W-1:0] c_rst = (c_id == RSP) ? RSP_INIT : '0;
    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= c_rst;
      end else if (bus.wb_valid && (bus.wb_dstM == c_id)) begin
        r_q <= bus.wb_valM;
      end else if (bus.wb_valid && (bus.wb_dstE == c_id)) begin
        r_q <= bus.wb_valE;
      end
    end

    assign w_rf[gi] = r_q;
  end : g_reg

  assign w_rf[15] = '0;

  // Read port with bypass: a read of a register being written this cycle
  // returns the value that lands in it (M over E). RNONE never matches a
  // bypass because it must always read as zero.
  function automatic logic [W-1:0] read_port(
    input logic [3:0]         src,
    input logic               wb_valid,
    input logic [3:0]         dstE,
    input logic [3:0]         dstM,
    input logic [W-1:0]       valE,
    input logic [W-1:0]       valM,
    input logic [15:0][W-1:0] rf
  );
    if (src == RNONE)                  return '0;
    else if (wb_valid && dstM == src)  return valM;
    else if (wb_valid && dstE == src)  return valE;
    else                               return rf[src];
  endfunction

  always_comb begin
    w_opA = read_port(w_srcA, bus.wb_valid, bus.wb_dstE, bus.wb_dstM,
                      bus.wb_valE, bus.wb_valM, w_rf);
    w_opB = read_port(w_srcB, bus.wb_valid, bus.wb_dstE, bus.wb_dstM,
                      bus.wb_valE, bus.wb_valM, w_rf);
  end

  // Operand registers hold their last decode while no request is present.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valA      <= '0;
      r_valB      <= '0;
      r_srcA_q    <= RNONE;
      r_srcB_q    <= RNONE;
      r_out_valid <= 1'b0;
    end else if (bus.dec_valid) begin
      r_valA      <= w_opA;
      r_valB      <= w_opB;
      r_srcA_q    <= w_srcA;
      r_srcB_q    <= w_srcB;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.valA      = r_valA;
  assign bus.valB      = r_valB;
  assign bus.srcA_q    = r_srcA_q;
  assign bus.srcB_q    = r_srcB_q;
  assign bus.out_valid = r_out_valid;

endmodule : decode_regfile
`default_nettype wire

// File: tb/tb_decode_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_decode_regfile                                        |
// | Purpose   : Self-checking bench for decode_regfile: directed vector  |
// |             table, asynchronous reset sequence, random traffic       |
// |             against a behavioural register-file model.               |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_decode_regfile;

  localparam int          W        = 64;
  localparam logic [63:0] RSP_INIT = 64'h0000_0000_0000_0200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_regfile_if #(.W(W)) bus ();

  decode_regfile #(.W(W), .RSP_INIT(RSP_INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [3:0] ic, input logic [3:0] ra,
                       input logic [3:0] rb, input logic wv, input logic [3:0] de,
                       input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
    bus.dec_valid = dv; bus.icode = ic; bus.rA = ra; bus.rB = rb;
    bus.wb_valid = wv; bus.wb_dstE = de; bus.wb_dstM = dm;
    bus.wb_valE = ve; bus.wb_valM = vm;
  endtask

  task automatic idle();
    drive(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_rf [16];
  logic [63:0] m_valA, m_valB;
  logic [3:0]  m_srcA, m_srcB;
  logic        m_ov;

  function automatic logic [3:0] ref_srcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB})             return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] ref_srcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6})       return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_rf[4] = RSP_INIT;
    m_valA = '0; m_valB = '0; m_srcA = 4'hF; m_srcB = 4'hF; m_ov = 1'b0;
  endtask

  // Reads after a same-cycle write see the written value, so the model
  // simply applies the writeback first and then reads.
  task automatic model_step();
    if (bus.wb_valid) begin
      m_rf[bus.wb_dstE] = bus.wb_valE;
      m_rf[bus.wb_dstM] = bus.wb_valM;
      m_rf[15] = '0;
    end
    if (bus.dec_valid) begin
      m_srcA = ref_srcA(bus.icode, bus.rA);
      m_srcB = ref_srcB(bus.icode, bus.rB);
      m_valA = m_rf[m_srcA];
      m_valB = m_rf[m_srcB];
      m_ov   = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        dv;
    logic [3:0]  ic, ra, rb;
    logic        wv;
    logic [3:0]  de, dm;
    logic [63:0] ve, vm;
    logic [63:0] e_valA, e_valB;
    logic [3:0]  e_srcA, e_srcB;
    logic        e_ov;
  } vec_t;

  vec_t vt[13];

  initial begin
    // popq right after reset reads the initial stack pointer on both ports
    vt[0]  = '{1, 4'hB, 4'h3, 4'hF, 0, 4'hF, 4'hF, 64'h0,   64'h0,   RSP_INIT, RSP_INIT, 4'h4, 4'h4, 1};
    vt[1]  = '{0, 4'h1, 4'hF, 4'hF, 1, 4'h2, 4'hF, 64'h55,  64'h0,   RSP_INIT, RSP_INIT, 4'h4, 4'h4, 0};
    vt[2]  = '{1, 4'h6, 4'h2, 4'hF, 0, 4'hF, 4'hF, 64'h0,   64'h0,   64'h55,   64'h0,    4'h2, 4'hF, 1};
    // same-cycle M write and rrmovq read of the same register
    vt[3]  = '{1, 4'h2, 4'h7, 4'hF, 1, 4'hF, 4'h7, 64'h0,   64'hAB,  64'hAB,   64'h0,    4'h7, 4'hF, 1};
    vt[4]  = '{0, 4'h0, 4'h0, 4'h0, 1, 4'h4, 4'h4, 64'h10,  64'h20,  64'hAB,   64'h0,    4'h7, 4'hF, 0};
    vt[5]  = '{1, 4'h4, 4'h4, 4'h2, 0, 4'hF, 4'hF, 64'h0,   64'h0,   64'h20,   64'h55,   4'h4, 4'h2, 1};
    // writes to RNONE are dropped, RNONE reads as zero
    vt[6]  = '{1, 4'h4, 4'hF, 4'h7, 1, 4'hF, 4'hF, 64'hFF,  64'hFF,  64'h0,    64'hAB,   4'hF, 4'h7, 1};
    vt[7]  = '{1, 4'h0, 4'h2, 4'h2, 0, 4'hF, 4'hF, 64'h0,   64'h0,   64'h0,    64'h0,    4'hF, 4'hF, 1};
    vt[8]  = '{1, 4'hC, 4'h2, 4'h4, 0, 4'hF, 4'hF, 64'h0,   64'h0,   64'h0,    64'h0,    4'hF, 4'hF, 1};
    vt[9]  = '{1, 4'h6, 4'h1, 4'h3, 1, 4'h1, 4'h3, 64'h111, 64'h333, 64'h111,  64'h333,  4'h1, 4'h3, 1};
    // E and M both target reg 5 in the read cycle: M must win
    vt[10] = '{1, 4'hA, 4'h5, 4'hF, 1, 4'h5, 4'h5, 64'h5E,  64'h5F,  64'h5F,   64'h20,   4'h5, 4'h4, 1};
    vt[11] = '{1, 4'h8, 4'h1, 4'hF, 0, 4'hF, 4'hF, 64'h0,   64'h0,   64'h0,    64'h20,   4'hF, 4'h4, 1};
    vt[12] = '{1, 4'h9, 4'h0, 4'h0, 0, 4'hF, 4'hF, 64'h0,   64'h0,   64'h20,   64'h20,   4'h4, 4'h4, 1};
  end

  task automatic chk_out(input string tag, input logic [63:0] ea, input logic [63:0] eb,
                         input logic [3:0] sa, input logic [3:0] sb, input logic ov);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ov));
    chk({tag, ".valA"},      bus.valA,           ea);
    chk({tag, ".valB"},      bus.valB,           eb);
    chk({tag, ".srcA_q"},    64'(bus.srcA_q),    64'(sa));
    chk({tag, ".srcB_q"},    64'(bus.srcB_q),    64'(sb));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) tick();
    chk_out("reset", '0, '0, 4'hF, 4'hF, 1'b0);
    rst = 1'b0;
    #2;

    // directed table
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].dv, vt[i].ic, vt[i].ra, vt[i].rb, vt[i].wv,
            vt[i].de, vt[i].dm, vt[i].ve, vt[i].vm);
      tick();
      chk_out($sformatf("vec%0d", i), vt[i].e_valA, vt[i].e_valB,
              vt[i].e_srcA, vt[i].e_srcB, vt[i].e_ov);
    end

    // no register moved because of the RNONE write: re-read 2 and 7
    drive(1'b1, 4'h6, 4'h2, 4'h7, 1'b0, 4'hF, 4'hF, '0, '0);
    tick();
    chk_out("rnone_keep", 64'h55, 64'hAB, 4'h2, 4'h7, 1'b1);

    // asynchronous reset in mid-cycle clears outputs without a clock edge
    drive(1'b1, 4'h6, 4'h1, 4'h3, 1'b0, 4'hF, 4'hF, '0, '0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", '0, '0, 4'hF, 4'hF, 1'b0);
    // a write and a decode presented across an edge under reset are dropped
    drive(1'b1, 4'h6, 4'h2, 4'h4, 1'b1, 4'h2, 4'h4, 64'hDEAD, 64'hBEEF);
    tick();
    chk_out("rst_hold", '0, '0, 4'hF, 4'hF, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    drive(1'b1, 4'hB, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, '0, '0);
    tick();
    chk_out("post_rst_popq", RSP_INIT, RSP_INIT, 4'h4, 4'h4, 1'b1);
    drive(1'b1, 4'h6, 4'h2, 4'h1, 1'b0, 4'hF, 4'hF, '0, '0);
    tick();
    chk_out("post_rst_clear", '0, '0, 4'h2, 4'h1, 1'b1);

    // random traffic against the model, starting from a fresh reset
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 2) != 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            {$urandom, $urandom}, {$urandom, $urandom});
      model_step();
      tick();
      chk_out($sformatf("rnd%0d", n), m_valA, m_valB, m_srcA, m_srcB, m_ov);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

endmodule : tb_decode_regfile
`default_nettype wire

// File: doc/decode_regfile.md
DECODE_REGFILE -- requirements
Module: decode_regfile

Interface
REQ-001 The block SHALL have parameter W, default 64, meaning register/data width.
REQ-002 The block SHALL have parameter RSP_INIT, default 64'h0000_0000_0000_0200, meaning the %rsp (reg 4) value after reset.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-005 The block SHALL have port dec_valid, input, 1, meaning a decode request is present this cycle.
REQ-006 The block SHALL have port icode, input, 4, meaning the Y86-64 instruction code of the decode request.
REQ-007 The block SHALL have ports rA and rB, input, 4 each, meaning the instruction register specifiers.
REQ-008 The block SHALL have port wb_valid, input, 1, meaning a writeback is present this cycle.
REQ-009 The block SHALL have ports wb_dstE and wb_dstM, input, 4 each, meaning writeback destinations; 4'hF means none.
REQ-010 The block SHALL have ports wb_valE and wb_valM, input, W each, meaning writeback data.
REQ-011 The block SHALL have ports valA and valB, output, W each, meaning registered operand values.
REQ-012 The block SHALL have ports srcA_q and srcB_q, output, 4 each, meaning the registered source IDs matching valA/valB.
REQ-013 The block SHALL have port out_valid, output, 1, meaning valA/valB/srcA_q/srcB_q hold a completed decode.

Function
REQ-014 The block SHALL hold 15 W-bit registers, ids 0-14; id 15 (RNONE) reads as 0 and ignores writes.
REQ-015 The block SHALL compute srcA combinationally as: rA for icode 2,4,6,A; 4 for icode 9,B; otherwise 15.
REQ-016 The block SHALL compute srcB combinationally as: rB for icode 4,5,6; 4 for icode 8,9,A,B; otherwise 15.
REQ-017 The block SHALL, on a rising edge with wb_valid=1, write wb_valE to wb_dstE and then wb_valM to wb_dstM.
REQ-018 When wb_dstE equals wb_dstM (not 15), the block SHALL store wb_valM in that register.
REQ-019 When wb_valid=0, the block SHALL leave the register file unchanged.
REQ-020 The block SHALL, on a rising edge with dec_valid=1, register valA=reg[srcA], valB=reg[srcB], srcA_q, srcB_q, and set out_valid=1; latency is one cycle.
REQ-021 When a write and a read hit the same register in the same cycle, the block SHALL return the value being written (bypass), with M taking priority over E.
REQ-022 The block SHALL, on a rising edge with dec_valid=0, clear out_valid and hold valA/valB/srcA_q/srcB_q.
REQ-023 Unknown icodes (C-F) and halt/nop/jXX SHALL decode as srcA=srcB=15, giving valA=valB=0.
REQ-024 The block SHALL accept one decode and one writeback every cycle with no back-pressure.

Reset
REQ-025 While rst=1, the block SHALL set registers 0-3 and 5-14 to 0 and register 4 to RSP_INIT.
REQ-026 While rst=1, the block SHALL set valA=0, valB=0, srcA_q=15, srcB_q=15 and out_valid=0.
REQ-027 Reset asserted mid-operation SHALL discard any same-edge write or decode.
REQ-028 The first decode after reset deassertion SHALL complete normally on the following edge.

Structure
REQ-029 The shared y86_pkg SHALL hold the icode constants (I_HALT through I_POPQ), RNONE=4'hF and RSP=4'h4.
REQ-030 Source selection SHALL be a sub-module named y86_src_sel (inputs icode, rA, rB; outputs srcA, srcB); the register file and bypass SHALL stay in decode_regfile.

Verification
REQ-031 Reset then decode popq (icode B, rA=3): the next cycle SHALL give srcA_q=4, valA=RSP_INIT, srcB_q=4, valB=RSP_INIT, out_valid=1.
REQ-032 Write wb_dstE=2, valE=0x55, then decode OPq with rA=2, rB=15: the next cycle SHALL give valA=0x55 and valB=0.
REQ-033 In the same cycle, write wb_dstM=7, valM=0xAB and decode rrmovq with rA=7: the next cycle SHALL give valA=0xAB (bypass).
REQ-034 Write wb_dstE=4, valE=0x10 and wb_dstM=4, valM=0x20: a later read of reg 4 SHALL return 0x20.
REQ-035 Write to dst 15 with value 0xFF, then decode rmmovq with rA=15: the next cycle SHALL give valA=0 and no register SHALL change.
REQ-036 Assert rst asynchronously mid-cycle after regs are written: out_valid SHALL go to 0 immediately and the next popq decode SHALL return RSP_INIT.
